// File: rtl/alu_signed_pipe_pkg.sv
// Shared definitions for the signed pipelined ALU: operation codes and opcode width.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD      = 3'b000,
        OP_SUB      = 3'b001,
        OP_ABS_SUM  = 3'b010,
        OP_ABS_DIFF = 3'b011,
        OP_LT       = 3'b100
    } op_e;

endpackage

// File: rtl/alu_signed_pipe_core.sv
// Combinational signed ALU datapath: exact WIDTH+1-bit arithmetic mapped to WIDTH bits,
// with optional clamping of unrepresentable results.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             lt,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] mag_sum;
    logic [WIDTH:0] mag_diff;

    assign sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

    // Magnitudes are unsigned WIDTH+1-bit values; 2^WIDTH (from MIN+MIN) still fits.
    assign mag_sum  = sum[WIDTH]  ? -sum  : sum;
    assign mag_diff = diff[WIDTH] ? -diff : diff;

    assign lt = diff[WIDTH];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                ovf    = sum[WIDTH] ^ sum[WIDTH-1];
                result = sum[WIDTH-1:0];
                if (SATURATE && ovf)
                    result = sum[WIDTH] ? MIN_VAL : MAX_VAL;
            end
            OP_SUB: begin
                ovf    = diff[WIDTH] ^ diff[WIDTH-1];
                result = diff[WIDTH-1:0];
                if (SATURATE && ovf)
                    result = diff[WIDTH] ? MIN_VAL : MAX_VAL;
            end
            OP_ABS_SUM: begin
                ovf    = |mag_sum[WIDTH:WIDTH-1];
                result = mag_sum[WIDTH-1:0];
                if (SATURATE && ovf)
                    result = MAX_VAL;
            end
            OP_ABS_DIFF: begin
                ovf    = |mag_diff[WIDTH:WIDTH-1];
                result = mag_diff[WIDTH-1:0];
                if (SATURATE && ovf)
                    result = MAX_VAL;
            end
            OP_LT: begin
                result = {{(WIDTH-1){1'b0}}, lt};
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_signed_pipe.sv
// Two-stage valid/ready pipelined signed ALU with a saturating overflow event counter.
// Stage 1 registers operands, stage 2 registers the computed result.
module alu_signed_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter bit SATURATE = 1'b0,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [OP_W-1:0]    op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               ovf,
    output logic               lt,
    output logic               err,
    output logic [COUNT_W-1:0] ovf_count,
    input  logic               clr_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             s2_valid;
    logic             s2_adv;

    logic [WIDTH-1:0] core_result;
    logic             core_ovf;
    logic             core_lt;
    logic             core_err;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            // in_ready implies any held beat moves on, so the slot may empty here.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    alu_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result),
        .ovf    (core_ovf),
        .lt     (core_lt),
        .err    (core_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            lt       <= 1'b0;
            err      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result <= core_result;
                ovf    <= core_ovf;
                lt     <= core_lt;
                err    <= core_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_count) begin
            ovf_count <= '0;
        end else if (out_valid && out_ready && ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + COUNT_W'(1);
        end
    end

endmodule
